i2c_master_arbiter: RTL and testbench



---
 rtl/i2c_master_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: shares one i2c_master between NREQ requesters.
// Grants one requester at a time, holds its address, direction and byte count
// on the master's control inputs, and services the write-data and read-data
// handshakes for it.
// Build option: define I2C_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins);
// otherwise round-robin arbitration is used.
`timescale 1ns/1ps
module i2c_master_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        freq_sel,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   rd_nwr,
    input  logic [7*NREQ-1:0] addr,
    input  logic [2*NREQ-1:0] nbytes,
    input  logic [8*NREQ-1:0] wdata,
    input  logic [NREQ-1:0]   wvalid,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   wreq,
    output logic [7:0]        rdata,
    output logic [NREQ-1:0]   rvalid,
    output logic [NREQ-1:0]   done,
    output logic              m_start,
    output logic              m_read_nwrite,
    output logic              m_data_valid,
    output logic [1:0]        m_byte_size,
    output logic [1:0]        m_freq_sel,
    output logic [6:0]        m_addr,
    output logic [7:0]        m_data_i,
    input  logic              m_busy,
    input  logic              m_new_data,
    input  logic              m_data_req,
    input  logic [7:0]        m_data_o
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_XFER, S_DONE} state_t;

    state_t          r_state, w_next;
    logic            r_busy_s, r_busy_q, r_ndat_s, r_ndat_q, r_dreq_s;
    logic            w_busy_rise, w_busy_fall, w_ndat_fall;
    logic            w_launch, w_to_done, w_win_vld, w_hs;
    logic [IW-1:0]   w_win_idx;
    logic [NREQ-1:0] w_win_oh;
    logic [6:0]      w_win_addr;
    logic            w_win_rnw;
    logic [1:0]      w_win_nb;
    logic [7:0]      w_gwdata;

    logic [NREQ-1:0] r_grant, r_wreq, r_rvalid, r_done;
    logic [7:0]      r_rdata, r_m_data_i;
    logic            r_m_start, r_m_rnw, r_m_dvalid;
    logic [1:0]      r_m_bsz, r_m_freq;
    logic [6:0]      r_m_addr;
    logic [2:0]      r_cnt;
    logic [13:0]     r_hold;

    // Write byte hold time: 9 SCL bit periods, counted down to zero.
    function automatic logic [13:0] hold_cycles(input logic [1:0] fs);
        case (fs)
            2'd0:    return 14'd287;
            2'd1:    return 14'd1151;
            2'd2:    return 14'd2303;
            default: return 14'd9215;
        endcase
    endfunction

    assign w_busy_rise = r_busy_s & ~r_busy_q;
    assign w_busy_fall = ~r_busy_s & r_busy_q;
    assign w_ndat_fall = ~r_ndat_s & r_ndat_q;

    // Bring the master's status lines into clk and keep one older copy for edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_s <= 1'b0; r_busy_q <= 1'b0;
            r_ndat_s <= 1'b0; r_ndat_q <= 1'b0;
            r_dreq_s <= 1'b0;
        end else begin
            r_busy_s <= m_busy;     r_busy_q <= r_busy_s;
            r_ndat_s <= m_new_data; r_ndat_q <= r_ndat_s;
            r_dreq_s <= m_data_req;
        end
    end

`ifdef I2C_ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest asserted request index wins.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                w_win_vld = 1'b1;
                w_win_idx = IW'(k);
            end
        end
    end
`else
    logic [IW-1:0] r_last;

    // Round-robin: search starts one past the last granted requester and wraps.
    always_comb begin
        int j;
        j         = 0;
        w_win_vld = 1'b0;
        w_win_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(r_last) + k) % NREQ;
            if (!w_win_vld && req[j]) begin
                w_win_vld = 1'b1;
                w_win_idx = IW'(j);
            end
        end
    end

    // Pointer moves to the winner whenever a grant is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_last <= '0;
        else if (w_launch) r_last <= w_win_idx;
    end
`endif

    // Pick out the winner's fields and the granted requester's write byte.
    always_comb begin
        w_win_oh   = '0;
        w_win_addr = '0;
        w_win_rnw  = 1'b0;
        w_win_nb   = '0;
        w_gwdata   = '0;
        w_hs       = |(r_wreq & wvalid);
        for (int k = 0; k < NREQ; k++) begin
            if (IW'(k) == w_win_idx) begin
                w_win_oh[k] = 1'b1;
                w_win_addr  = addr[7*k +: 7];
                w_win_rnw   = rd_nwr[k];
                w_win_nb    = nbytes[2*k +: 2];
            end
            if (r_grant[k]) w_gwdata = wdata[8*k +: 8];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // FSM next state and the launch/finish strobes.
    always_comb begin
        w_next    = r_state;
        w_launch  = 1'b0;
        w_to_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_win_vld && !r_busy_s) begin
                    w_launch = 1'b1;
                    w_next   = S_LAUNCH;
                end
            end
            S_LAUNCH: if (w_busy_rise) w_next = S_XFER;
            S_XFER: begin
                if (w_busy_fall) begin
                    w_to_done = 1'b1;
                    w_next    = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Grant, master configuration, write/read data handshakes and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant <= '0; r_wreq <= '0; r_rvalid <= '0; r_done <= '0;
            r_rdata <= '0; r_m_data_i <= '0;
            r_m_start <= 1'b0; r_m_rnw <= 1'b0; r_m_dvalid <= 1'b0;
            r_m_bsz <= '0; r_m_freq <= '0; r_m_addr <= '0;
            r_cnt <= '0; r_hold <= '0;
        end else begin
            r_wreq   <= '0;
            r_rvalid <= '0;
            r_done   <= '0;
            if (w_launch) begin
                r_grant   <= w_win_oh;
                r_m_addr  <= w_win_addr;
                r_m_rnw   <= w_win_rnw;
                r_m_bsz   <= w_win_nb;
                r_m_freq  <= freq_sel;
                r_m_start <= 1'b1;
                r_cnt     <= '0;
            end
            if (r_state == S_LAUNCH && w_busy_rise) r_m_start <= 1'b0;
            if (r_m_dvalid) begin
                if (r_hold == '0) r_m_dvalid <= 1'b0;
                else              r_hold     <= r_hold - 14'd1;
            end
            if (r_state == S_XFER && !r_m_rnw) begin
                if (w_hs) begin
                    r_m_data_i <= w_gwdata;
                    r_m_dvalid <= 1'b1;
                    r_hold     <= hold_cycles(r_m_freq);
                    r_cnt      <= r_cnt + 3'd1;
                end else if (r_dreq_s && !r_m_dvalid && r_cnt <= {1'b0, r_m_bsz}) begin
                    r_wreq <= r_grant;
                end
            end
            if (r_state == S_XFER && r_m_rnw && w_ndat_fall) begin
                r_rdata  <= m_data_o;
                r_rvalid <= r_grant;
            end
            if (w_to_done) begin
                r_done     <= r_grant;
                r_grant    <= '0;
                r_m_dvalid <= 1'b0;
            end
        end
    end

    assign grant         = r_grant;
    assign wreq          = r_wreq;
    assign rdata         = r_rdata;
    assign rvalid        = r_rvalid;
    assign done          = r_done;
    assign m_start       = r_m_start;
    assign m_read_nwrite = r_m_rnw;
    assign m_data_valid  = r_m_dvalid;
    assign m_byte_size   = r_m_bsz;
    assign m_freq_sel    = r_m_freq;
    assign m_addr        = r_m_addr;
    assign m_data_i      = r_m_data_i;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Testbench for i2c_master_arbiter: behavioural i2c_master and requester
// models, expected-value queues filled with the stimulus and drained by monitors.
`timescale 1ns/1ps
module tb_i2c_master_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  freq_sel;
    logic [3:0]  req, rd_nwr, wvalid, grant, wreq, rvalid, done;
    logic [27:0] addr;
    logic [7:0]  nbytes;
    logic [31:0] wdata;
    logic [7:0]  rdata;
    logic        m_start, m_read_nwrite, m_data_valid;
    logic [1:0]  m_byte_size, m_freq_sel;
    logic [6:0]  m_addr;
    logic [7:0]  m_data_i;
    logic        m_busy, m_new_data, m_data_req;
    logic [7:0]  m_data_o;

    int          n_chk = 0;
    int          n_fail = 0;
    int          wreq_cnt = 0;
    logic [3:0]  hs, stray, prev_grant;
    logic [7:0]  wq [4][$];
    logic [7:0]  slave_q[$];
    logic [31:0] exp_bus[$], exp_rd[$], exp_done[$], exp_grant[$];

    i2c_master_arbiter #(.NREQ(4)) dut (
        .clk(clk), .rst(rst), .freq_sel(freq_sel), .req(req), .rd_nwr(rd_nwr),
        .addr(addr), .nbytes(nbytes), .wdata(wdata), .wvalid(wvalid),
        .grant(grant), .wreq(wreq), .rdata(rdata), .rvalid(rvalid), .done(done),
        .m_start(m_start), .m_read_nwrite(m_read_nwrite), .m_data_valid(m_data_valid),
        .m_byte_size(m_byte_size), .m_freq_sel(m_freq_sel), .m_addr(m_addr),
        .m_data_i(m_data_i), .m_busy(m_busy), .m_new_data(m_new_data),
        .m_data_req(m_data_req), .m_data_o(m_data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_pop(input string tag, input logic [31:0] got, inout logic [31:0] q[$]);
        if (q.size() > 0) check(tag, got, q.pop_front());
        else              check({tag, "_unexpected"}, got, 32'hFFFF_FFFF);
    endtask

    function automatic logic [31:0] mkcfg(input logic [1:0] f, input logic [1:0] nb,
                                          input logic rnw, input logic [6:0] a);
        return 32'({f, nb, rnw, a});
    endfunction

    task automatic setup_req(input int i, input logic [6:0] a, input logic rnw, input logic [1:0] nb);
        addr[7*i +: 7]   = a;
        rd_nwr[i]        = rnw;
        nbytes[2*i +: 2] = nb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural i2c_master for one transaction; exp_cfg = {freq, nbytes, rd_nwr, addr}.
    task automatic master_serve(input logic [31:0] exp_cfg);
        int t;
        t = 0;
        while (!m_start && t < 20) begin tick(); t++; end
        check("start_seen", 32'(m_start), 32'h1);
        if (!m_start) return;
        check("cfg_at_grant", 32'({m_freq_sel, m_byte_size, m_read_nwrite, m_addr}), exp_cfg);
        check_pop("bus_addr", 32'({m_addr, m_read_nwrite}), exp_bus);
        tick();
        m_busy = 1'b1;
        t = 0;
        while (m_start && t < 10) begin tick(); t++; end
        check("start_drop", 32'(m_start), 32'h0);
        for (int b = 0; b <= int'(exp_cfg[9:8]); b++) begin
            if (!exp_cfg[7]) begin
                m_data_req = 1'b1;
                t = 0;
                while (!m_data_valid && t < 3000) begin tick(); t++; end
                check("dvalid_seen", 32'(m_data_valid), 32'h1);
                check_pop("bus_data", 32'(m_data_i), exp_bus);
                m_data_req = 1'b0;
                t = 0;
                while (m_data_valid && t < 12000) begin tick(); t++; end
            end else begin
                m_data_o = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
                repeat (2) tick();
                m_new_data = 1'b1;
                repeat (3) tick();
                m_new_data = 1'b0;
                repeat (6) tick();
            end
        end
        check("cfg_hold", 32'({m_freq_sel, m_byte_size, m_read_nwrite, m_addr}), exp_cfg);
        tick();
        m_busy = 1'b0;
        t = 0;
        while (done == 4'h0 && t < 10) begin tick(); t++; end
        check("done_seen", 32'(done != 4'h0), 32'h1);
    endtask

    // Requester model: answer each wreq with the next queued byte.
    initial begin
        hs = '0; wvalid = '0; wdata = '0;
        forever begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (wreq[i] && !hs[i] && wq[i].size() > 0) begin
                    wdata[8*i +: 8] = wq[i].pop_front();
                    hs[i] = 1'b1;
                end else begin
                    hs[i] = 1'b0;
                end
            end
            wvalid = hs | stray;
        end
    end

    // Output monitor: grants, done pulses and read bytes against the queues.
    initial begin
        prev_grant = '0;
        forever begin
            @(negedge clk);
            if (wreq != 4'h0) wreq_cnt++;
            if (grant != prev_grant && grant != 4'h0) check_pop("grant", 32'(grant), exp_grant);
            prev_grant = grant;
            if (done != 4'h0)   check_pop("done", 32'(done), exp_done);
            if (rvalid != 4'h0) check_pop("rdata", 32'({rvalid, rdata}), exp_rd);
        end
    end

    initial begin
        #400us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, w0, first, second;
        logic [31:0] cfg_a, cfg_b;
        rst = 1'b1; freq_sel = '0; req = '0; rd_nwr = '0; addr = '0; nbytes = '0;
        stray = '0; m_busy = 1'b0; m_new_data = 1'b0; m_data_req = 1'b0; m_data_o = '0;
        repeat (3) tick();
        check("rst_grant",  32'(grant), 32'h0);
        check("rst_wreq",   32'(wreq), 32'h0);
        check("rst_pulses", 32'({rvalid, done}), 32'h0);
        check("rst_rdata",  32'(rdata), 32'h0);
        check("rst_mctl",   32'({m_start, m_read_nwrite, m_data_valid, m_byte_size, m_freq_sel}), 32'h0);
        check("rst_maddr",  32'({m_addr, m_data_i}), 32'h0);
        rst = 1'b0;
        tick();

        // wvalid with no wreq and no request must be ignored.
        stray = 4'hF;
        repeat (10) tick();
        check("stray_wreq",   32'(wreq), 32'h0);
        check("stray_dvalid", 32'(m_data_valid), 32'h0);
        stray = 4'h0;
        repeat (3) tick();

        // Single write: requester 1, 0x2A, two bytes; req dropped while granted.
        freq_sel = 2'd0;
        setup_req(1, 7'h2A, 1'b0, 2'd1);
        wq[1].push_back(8'hA5); wq[1].push_back(8'h3C);
        exp_bus.push_back(32'h54); exp_bus.push_back(32'hA5); exp_bus.push_back(32'h3C);
        exp_grant.push_back(32'h2); exp_done.push_back(32'h2);
        req[1] = 1'b1;
        tick();
        check("grant_latency", 32'(grant), 32'h2);
        check("start_latency", 32'(m_start), 32'h1);
        req[1] = 1'b0;
        master_serve(mkcfg(2'd0, 2'd1, 1'b0, 7'h2A));
        repeat (4) tick();

        // Single read: requester 2, 0x50, three bytes; no wreq at all.
        freq_sel = 2'd2;
        setup_req(2, 7'h50, 1'b1, 2'd2);
        slave_q.push_back(8'h11); slave_q.push_back(8'h22); slave_q.push_back(8'h33);
        exp_rd.push_back(32'h411); exp_rd.push_back(32'h422); exp_rd.push_back(32'h433);
        exp_bus.push_back(32'hA1);
        exp_grant.push_back(32'h4); exp_done.push_back(32'h4);
        w0 = wreq_cnt;
        req[2] = 1'b1;
        master_serve(mkcfg(2'd2, 2'd2, 1'b1, 7'h50));
        req[2] = 1'b0;
        check("read_no_wreq", 32'(wreq_cnt - w0), 32'h0);
        repeat (4) tick();

        // Busy bus: master waits on another bus owner, so the arbiter sits in LAUNCH.
        freq_sel = 2'd1;
        setup_req(0, 7'h10, 1'b0, 2'd0);
        wq[0].push_back(8'hC3);
        exp_bus.push_back(32'h20); exp_bus.push_back(32'hC3);
        exp_grant.push_back(32'h1); exp_done.push_back(32'h1);
        req[0] = 1'b1;
        tick();
        check("busy_grant", 32'(grant), 32'h1);
        repeat (50) tick();
        check("launch_hold_start", 32'(m_start), 32'h1);
        check("launch_hold_grant", 32'(grant), 32'h1);
        master_serve(mkcfg(2'd1, 2'd0, 1'b0, 7'h10));
        req[0] = 1'b0;
        repeat (4) tick();

        // Contention between requesters 0 and 3 after requester 0 was last granted.
        freq_sel = 2'd0;
`ifdef I2C_ARB_FIXED_PRIO_EN
        first = 0; second = 3;
`else
        first = 3; second = 0;
`endif
        setup_req(0, 7'h11, 1'b0, 2'd0); wq[0].push_back(8'h0F);
        setup_req(3, 7'h33, 1'b0, 2'd0); wq[3].push_back(8'hF3);
        cfg_a = (first == 3) ? mkcfg(2'd0, 2'd0, 1'b0, 7'h33) : mkcfg(2'd0, 2'd0, 1'b0, 7'h11);
        cfg_b = (first == 3) ? mkcfg(2'd0, 2'd0, 1'b0, 7'h11) : mkcfg(2'd0, 2'd0, 1'b0, 7'h33);
        exp_bus.push_back(32'(cfg_a[6:0]) << 1); exp_bus.push_back((first == 3) ? 32'hF3 : 32'h0F);
        exp_bus.push_back(32'(cfg_b[6:0]) << 1); exp_bus.push_back((first == 3) ? 32'h0F : 32'hF3);
        exp_grant.push_back(32'h1 << first); exp_grant.push_back(32'h1 << second);
        exp_done.push_back(32'h1 << first);  exp_done.push_back(32'h1 << second);
        req = 4'b1001;
        master_serve(cfg_a);
        req[first] = 1'b0;
        t = 0;
        while (grant == 4'h0 && t < 10) begin tick(); t++; end
        check("regrant_latency", 32'(t), 32'h2);
        master_serve(cfg_b);
        req = 4'h0;
        repeat (4) tick();

        // Reset in the middle of a write, then a fresh request.
        setup_req(1, 7'h41, 1'b0, 2'd1);
        wq[1].push_back(8'h77); wq[1].push_back(8'h88);
        exp_grant.push_back(32'h2);
        req[1] = 1'b1;
        tick();
        m_busy = 1'b1;
        m_data_req = 1'b1;
        t = 0;
        while (!m_data_valid && t < 50) begin tick(); t++; end
        check("midwr_dvalid", 32'(m_data_valid), 32'h1);
        rst = 1'b1;
        #1;
        check("midrst_grant_wreq", 32'({grant, wreq, done, rvalid}), 32'h0);
        check("midrst_mctl", 32'({m_start, m_data_valid, m_read_nwrite, m_byte_size, m_freq_sel}), 32'h0);
        check("midrst_mdata", 32'({m_addr, m_data_i, rdata}), 32'h0);
        m_busy = 1'b0; m_data_req = 1'b0; req = 4'h0;
        wq[1].delete();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        setup_req(1, 7'h2A, 1'b0, 2'd0);
        wq[1].push_back(8'h5A);
        exp_bus.push_back(32'h54); exp_bus.push_back(32'h5A);
        exp_grant.push_back(32'h2); exp_done.push_back(32'h2);
        req[1] = 1'b1;
        tick();
        check("post_rst_grant", 32'(grant), 32'h2);
        master_serve(mkcfg(2'd0, 2'd0, 1'b0, 7'h2A));
        req = 4'h0;
        repeat (5) tick();

        check("expect_queues_empty",
              32'(exp_bus.size() + exp_rd.size() + exp_done.size() + exp_grant.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
